// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/return redirect controller.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_BOOT,
    ST_IDLE,
    ST_REDIR
  } state_t;

  localparam logic [4:0]  CAUSE_INT  = 5'h00;
  localparam logic [4:0]  CAUSE_ERET = 5'h10;

  localparam logic [31:0] DEF_RESET_VEC = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'hbfc0_0380;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Fixed-priority selector over the exception sources; index 0 wins.
module exc_prio_sel
  import exc_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]        valid,
  input  logic [5*NUM_SRC-1:0]      codes,
  input  logic [ADDR_W*NUM_SRC-1:0] pcs,
  output logic                      any,
  output logic [IDX_W-1:0]          index,
  output logic [4:0]                code,
  output logic [ADDR_W-1:0]         pc
);

  always_comb begin
    any   = '0;
    index = '0;
    code  = '0;
    pc    = '0;
    // Scan from the top down so the lowest asserted index is written last.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (valid[i-1]) begin
        any   = '1;
        index = IDX_W'(i - 1);
        code  = codes[(i-1)*5 +: 5];
        pc    = pcs[(i-1)*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Exception/return redirect controller: arbitrates exceptions and interrupts,
// owns EXL/EPC, and issues one registered redirect to fetch per event.
module exc_redirect_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned       NUM_SRC   = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_INT   = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter logic [4:0]        ERET_CODE = CAUSE_ERET
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        exc_valid,
  input  logic [5*NUM_SRC-1:0]      exc_code,
  input  logic [ADDR_W*NUM_SRC-1:0] exc_pc,
  input  logic [NUM_INT-1:0]        int_pending,
  input  logic [NUM_INT-1:0]        int_mask,
  input  logic                      int_ie,
  input  logic [ADDR_W-1:0]         int_pc,
  input  logic                      redirect_ready,
  output logic                      redirect_valid,
  output logic [ADDR_W-1:0]         redirect_addr,
  output logic                      flush,
  output logic                      exl,
  output logic [ADDR_W-1:0]         epc,
  output logic [4:0]                cause_code
);

  localparam int unsigned IDX_W = idx_w(NUM_SRC);

  state_t              state, state_n;
  logic                valid_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                exl_n;
  logic [ADDR_W-1:0]   epc_n;
  logic [4:0]          cause_n;

  logic                sel_any;
  logic [IDX_W-1:0]    sel_idx;
  logic [4:0]          sel_code;
  logic [ADDR_W-1:0]   sel_pc;
  logic                int_take;

  exc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_prio_sel (
    .valid (exc_valid),
    .codes (exc_code),
    .pcs   (exc_pc),
    .any   (sel_any),
    .index (sel_idx),
    .code  (sel_code),
    .pc    (sel_pc)
  );

  always_comb begin
    if (sel_any) begin
      assert (exc_valid[sel_idx]);
    end
  end

  assign int_take = int_ie & ~exl & (|(int_pending & int_mask));

  always_comb begin
    state_n = state;
    valid_n = redirect_valid;
    addr_n  = redirect_addr;
    exl_n   = exl;
    epc_n   = epc;
    cause_n = cause_code;
    unique case (state)
      ST_RST: begin
        state_n = ST_BOOT;
        valid_n = 1'b1;
        addr_n  = RESET_VEC;
      end
      ST_BOOT, ST_REDIR: begin
        // valid is always high here, so ready alone completes the handshake.
        if (redirect_ready) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
        end
      end
      ST_IDLE: begin
        if (sel_any) begin
          state_n = ST_REDIR;
          valid_n = 1'b1;
          if (sel_code == ERET_CODE) begin
            addr_n = epc;
            exl_n  = 1'b0;
          end else begin
            addr_n  = EXC_VEC;
            cause_n = sel_code;
            exl_n   = 1'b1;
            if (!exl) begin
              epc_n = sel_pc;
            end
          end
        end else if (int_take) begin
          state_n = ST_REDIR;
          valid_n = 1'b1;
          addr_n  = EXC_VEC;
          cause_n = CAUSE_INT;
          exl_n   = 1'b1;
          epc_n   = int_pc;
        end
      end
      default: begin
        state_n = ST_RST;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_RST;
      redirect_valid <= 1'b0;
      redirect_addr  <= RESET_VEC;
      exl            <= 1'b0;
      epc            <= '0;
      cause_code     <= '0;
    end else begin
      state          <= state_n;
      redirect_valid <= valid_n;
      redirect_addr  <= addr_n;
      exl            <= exl_n;
      epc            <= epc_n;
      cause_code     <= cause_n;
    end
  end

  assign flush = redirect_valid;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Randomized plus directed bench for exc_redirect_ctrl against a transaction-level model.
module tb_exc_redirect_ctrl;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned NUM_INT = 8;
  localparam logic [31:0] RST_V   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_V   = 32'hbfc0_0380;

  logic                      clk = 1'b0;
  logic                      resetn;
  logic [NUM_SRC-1:0]        exc_valid;
  logic [5*NUM_SRC-1:0]      exc_code;
  logic [ADDR_W*NUM_SRC-1:0] exc_pc;
  logic [NUM_INT-1:0]        int_pending;
  logic [NUM_INT-1:0]        int_mask;
  logic                      int_ie;
  logic [ADDR_W-1:0]         int_pc;
  logic                      redirect_ready;
  logic                      redirect_valid;
  logic [ADDR_W-1:0]         redirect_addr;
  logic                      flush;
  logic                      exl;
  logic [ADDR_W-1:0]         epc;
  logic [4:0]                cause_code;

  exc_redirect_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .ADDR_W    (ADDR_W),
    .NUM_INT   (NUM_INT),
    .RESET_VEC (RST_V),
    .EXC_VEC   (EXC_V),
    .ERET_CODE (5'h10)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .int_pending    (int_pending),
    .int_mask       (int_mask),
    .int_ie         (int_ie),
    .int_pc         (int_pc),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .flush          (flush),
    .exl            (exl),
    .epc            (epc),
    .cause_code     (cause_code)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Model: "just reset" flag, one outstanding redirect, plus architectural state.
  logic        m_fresh;
  logic        m_busy;
  logic [31:0] m_addr;
  logic        m_exl;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;

  task automatic model_step();
    int hit;
    if (!resetn) begin
      m_fresh = 1'b1; m_busy = 1'b0; m_addr = RST_V;
      m_exl = 1'b0; m_epc = '0; m_cause = '0;
    end else if (m_fresh) begin
      m_fresh = 1'b0; m_busy = 1'b1; m_addr = RST_V;
    end else if (m_busy) begin
      if (redirect_ready) m_busy = 1'b0;
    end else begin
      hit = -1;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (exc_valid[i]) hit = i;
      if (hit >= 0) begin
        m_busy = 1'b1;
        if (exc_code[hit*5 +: 5] == 5'h10) begin
          m_addr = m_epc;
          m_exl  = 1'b0;
        end else begin
          m_addr  = EXC_V;
          m_cause = exc_code[hit*5 +: 5];
          if (!m_exl) m_epc = exc_pc[hit*32 +: 32];
          m_exl   = 1'b1;
        end
      end else if (int_ie && !m_exl && ((int_pending & int_mask) != 0)) begin
        m_busy  = 1'b1;
        m_addr  = EXC_V;
        m_cause = 5'h00;
        m_epc   = int_pc;
        m_exl   = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("valid", 64'(redirect_valid), 64'(m_busy));
    check("flush", 64'(flush), 64'(m_busy));
    check("addr",  64'(redirect_addr), 64'(m_addr));
    check("exl",   64'(exl), 64'(m_exl));
    check("epc",   64'(epc), 64'(m_epc));
    check("cause", 64'(cause_code), 64'(m_cause));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clr_inputs();
    exc_valid = '0; exc_code = '0; exc_pc = '0;
    int_pending = '0; int_mask = '0; int_ie = 1'b0; int_pc = '0;
  endtask

  task automatic set_src(input int unsigned i, input logic [4:0] c, input logic [31:0] p);
    exc_valid[i]        = 1'b1;
    exc_code[i*5 +: 5]  = c;
    exc_pc[i*32 +: 32]  = p;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  logic [31:0] held_addr;

  initial begin
    clr_inputs();
    redirect_ready = 1'b1;
    resetn = 1'b0;
    model_step();
    @(negedge clk);
    check("rst_valid", 64'(redirect_valid), 64'd0);
    check("rst_addr",  64'(redirect_addr), 64'(RST_V));
    check("rst_exl",   64'(exl), 64'd0);
    check("rst_epc",   64'(epc), 64'd0);
    do_reset();

    // Boot redirect visible for exactly one cycle with ready held high.
    tick();
    check("boot_valid", 64'(redirect_valid), 64'd1);
    check("boot_addr",  64'(redirect_addr), 64'(RST_V));
    tick();
    check("boot_done",  64'(redirect_valid), 64'd0);

    set_src(1, 5'h04, 32'h8000_0100);
    set_src(2, 5'h0c, 32'h8000_0999);
    tick();
    check("exc1_addr",  64'(redirect_addr), 64'(EXC_V));
    check("exc1_epc",   64'(epc), 64'h8000_0100);
    check("exc1_cause", 64'(cause_code), 64'h04);
    check("exc1_exl",   64'(exl), 64'd1);
    clr_inputs();
    tick();

    set_src(0, 5'h0a, 32'h8000_0200);
    tick();
    check("nest_addr", 64'(redirect_addr), 64'(EXC_V));
    check("nest_epc",  64'(epc), 64'h8000_0100);
    clr_inputs();
    tick();

    set_src(3, 5'h10, 32'h8000_0777);
    tick();
    check("eret_addr", 64'(redirect_addr), 64'h8000_0100);
    check("eret_exl",  64'(exl), 64'd0);
    clr_inputs();
    tick();

    int_pending[2] = 1'b1; int_mask[2] = 1'b1; int_ie = 1'b1; int_pc = 32'h8000_0300;
    tick();
    check("int_valid", 64'(redirect_valid), 64'd1);
    check("int_cause", 64'(cause_code), 64'h00);
    check("int_epc",   64'(epc), 64'h8000_0300);
    tick();
    tick();
    check("int_masked_by_exl", 64'(redirect_valid), 64'd0);
    tick();
    check("int_masked_by_exl2", 64'(redirect_valid), 64'd0);
    clr_inputs();

    // Stall fetch for 5 cycles while a fresh event is offered.
    redirect_ready = 1'b0;
    set_src(1, 5'h05, 32'h8000_0400);
    tick();
    held_addr = redirect_addr;
    clr_inputs();
    set_src(0, 5'h10, 32'h8000_0500);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", 64'(redirect_valid), 64'd1);
      check("stall_addr",  64'(redirect_addr), 64'(held_addr));
    end
    redirect_ready = 1'b1;
    tick();
    check("stall_accept", 64'(redirect_valid), 64'd0);
    clr_inputs();
    tick();

    // Reset in the middle of an outstanding redirect.
    redirect_ready = 1'b0;
    set_src(2, 5'h07, 32'h8000_0600);
    tick();
    tick();
    clr_inputs();
    resetn = 1'b0;
    #1;
    check("midrst_valid", 64'(redirect_valid), 64'd0);
    check("midrst_exl",   64'(exl), 64'd0);
    tick();
    resetn = 1'b1;
    redirect_ready = 1'b1;
    tick();
    check("reboot_addr", 64'(redirect_addr), 64'(RST_V));
    tick();

    for (int n = 0; n < 3000; n++) begin
      exc_valid = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        exc_code[s*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'h10 : 5'($urandom_range(0, 31));
        exc_pc[s*32 +: 32] = $urandom;
      end
      int_pending    = NUM_INT'($urandom);
      int_mask       = NUM_INT'($urandom);
      int_ie         = 1'($urandom);
      int_pc         = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      resetn         = ($urandom_range(0, 299) != 0);
      tick();
      resetn = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_redirect_ctrl.md
# exc_redirect_ctrl

Parametrised exception/return redirect controller between the writeback stage and fetch. It arbitrates exception reports from NUM_SRC pipeline sources plus masked interrupts, and owns the EXL and EPC state. It issues one registered redirect (boot vector, exception vector or EPC) with a valid/ready handshake to fetch, and holds a pipeline flush until fetch accepts.

## Interface
Parameters:
- NUM_SRC, 4, number of exception sources; index 0 has highest priority
- ADDR_W, 32, address width
- NUM_INT, 8, interrupt lines
- RESET_VEC, 32'hbfc0_0000, boot redirect address
- EXC_VEC, 32'hbfc0_0380, general exception vector
- ERET_CODE, 5'h10, cause code that denotes a return-from-exception

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- exc_valid  in  NUM_SRC  per-source exception report
- exc_code  in  5*NUM_SRC  per-source cause code, source i at [5i+4:5i]
- exc_pc  in  ADDR_W*NUM_SRC  per-source faulting PC
- int_pending  in  NUM_INT  raw interrupt lines
- int_mask  in  NUM_INT  interrupt enables
- int_ie  in  1  global interrupt enable
- int_pc  in  ADDR_W  PC of the oldest uncommitted instruction
- redirect_ready  in  1  fetch accepts the redirect
- redirect_valid  out  1  redirect pending
- redirect_addr  out  ADDR_W  redirect target
- flush  out  1  kill all in-flight instructions
- exl  out  1  exception level
- epc  out  ADDR_W  saved exception PC
- cause_code  out  5  last taken cause

## Operation
- States: RST, BOOT, IDLE, REDIR. Reset forces RST.
- RST goes to BOOT unconditionally.
- BOOT: redirect_addr=RESET_VEC; on valid&ready, go to IDLE.
- IDLE: arbitration, in priority order:
  - Lowest-index asserted exc_valid wins.
  - If its code==ERET_CODE: target=epc; clear exl.
  - Otherwise: target=EXC_VEC; cause_code=code; set exl; epc=exc_pc[i] only if exl was 0 (nested exceptions keep the original EPC).
  - If no exc_valid and int_ie & ~exl & |(int_pending & int_mask): cause_code=5'h00; epc=int_pc; exl=1; target=EXC_VEC.
  - Any taken event moves to REDIR.
- REDIR: hold redirect_addr; on valid&ready, go to IDLE.
- Inputs are ignored in RST, BOOT and REDIR. Sources are flushed, so no event queueing is needed.
- flush = redirect_valid.

## Timing
- All outputs are registered. Reset values:
  - redirect_valid=0, flush=0, redirect_addr=RESET_VEC
  - exl=0, epc=0, cause_code=0
- First edge after resetn deasserts: RST to BOOT. redirect_valid=1 in the following cycle.
- Event latency: an event sampled in IDLE at edge T gives redirect_valid, flush, exl, epc and cause_code updated after T (1 cycle).
- Handshake:
  - redirect_valid and redirect_addr stay stable until the edge where valid&ready.
  - redirect_valid=0 the cycle after acceptance.
  - An event present in the acceptance cycle is dropped.
  - The earliest next event is sampled one cycle after acceptance.
- Simultaneous exception and interrupt: the exception wins, and the interrupt is re-evaluated in a later IDLE cycle.
- ERET while exl=0: still redirects to epc; exl stays 0.
- resetn asserted mid-REDIR: immediate return to reset values, then the boot sequence repeats.

## Structure
- Package exc_pkg:
  - state enum {RST, BOOT, IDLE, REDIR}
  - cause constants: INT=5'h00, ERET=5'h10
  - default vector constants
- Sub-module exc_prio_sel: combinational fixed-priority selector over NUM_SRC. Outputs any, index, code, pc.

## Test plan
- Reset release, redirect_ready=1: redirect_valid=1 with addr 32'hbfc0_0000 for exactly one cycle, then IDLE.
- exc_valid=4'b0110, src1 code 5'h04 pc 32'h8000_0100, src2 code 5'h0c: addr=32'hbfc0_0380, epc=32'h8000_0100, cause_code=5'h04, exl=1.
- With exl=1, src0 code 5'h0a pc 32'h8000_0200: redirect to EXC_VEC; epc unchanged at 32'h8000_0100.
- src3 code 5'h10: addr=epc=32'h8000_0100, exl to 0.
- int_pending[2]=1, int_mask[2]=1, int_ie=1, int_pc=32'h8000_0300: cause 0, epc=32'h8000_0300. Repeat with exl=1: no redirect.
- redirect_ready held 0 for 5 cycles with a new exc_valid injected: addr stable, the new event is ignored, and acceptance happens on the 6th cycle.
